// File: rtl/tisc_pkg.sv
// Shared types and constants for the TISC multi-cycle control unit.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package tisc_pkg;

  // Instruction opcodes carried in instr[15:12]; values 6..E are illegal.
  typedef enum logic [3:0] {
    OP_ADD  = 4'h0,
    OP_SUB  = 4'h1,
    OP_AND  = 4'h2,
    OP_OR   = 4'h3,
    OP_LD   = 4'h4,
    OP_ST   = 4'h5,
    OP_HALT = 4'hF
  } opcode_e;

  // Control FSM states.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    HALT   = 3'd4
  } state_e;

  // ALU function select encodings (equal to opcode[1:0] for ALU ops).
  localparam logic [1:0] ALU_ADD = 2'd0;
  localparam logic [1:0] ALU_SUB = 2'd1;
  localparam logic [1:0] ALU_AND = 2'd2;
  localparam logic [1:0] ALU_OR  = 2'd3;

  // Decoded attributes of the latched opcode.
  typedef struct packed {
    logic [1:0] alu_sel;
    logic       mem_op;
    logic       mem_to_reg;
    logic       is_reg_wr;
    logic       is_mem_wr;
    logic       is_halt;
    logic       is_illegal;
  } decode_t;

  // True for opcodes that have no defined meaning.
  function automatic logic op_is_illegal(input logic [3:0] op);
    return (op >= 4'h6) && (op <= 4'hE);
  endfunction

endpackage

// File: rtl/tisc_control_unit_if.sv
// Control-unit <-> datapath signal bundle.
// Latency: n/a (wires only).
// Backpressure: mem_ready from the data memory stretches LD/ST execution.
interface tisc_control_unit_if #(
  parameter int RETIRE_W = 16
);
  logic                start;
  logic [3:0]          opcode;
  logic                mem_ready;
  logic [1:0]          alu_sel;
  logic                reg_write_en;
  logic                mem_write_en;
  logic                mem_to_reg;
  logic                mem_op;
  logic                pc_en;
  logic                busy;
  logic                halted;
  logic                illegal;
  logic [RETIRE_W-1:0] retired;

  // Control unit side.
  modport master (
    input  start, opcode, mem_ready,
    output alu_sel, reg_write_en, mem_write_en, mem_to_reg, mem_op,
           pc_en, busy, halted, illegal, retired
  );

  // Datapath / environment side.
  modport slave (
    output start, opcode, mem_ready,
    input  alu_sel, reg_write_en, mem_write_en, mem_to_reg, mem_op,
           pc_en, busy, halted, illegal, retired
  );
endinterface

// File: rtl/tisc_opcode_decoder.sv
// Purely combinational opcode decoder for the latched instruction opcode.
// Latency: 0 cycles.
// Backpressure: none.
module tisc_opcode_decoder
  import tisc_pkg::*;
(
  input  logic [3:0] op,
  output decode_t    dec
);

  // Map opcode to ALU select, memory attributes and write-strobe classes.
  always_comb begin
    dec = '0;
    case (op)
      OP_ADD: begin dec.alu_sel = ALU_ADD; dec.is_reg_wr = 1'b1; end
      OP_SUB: begin dec.alu_sel = ALU_SUB; dec.is_reg_wr = 1'b1; end
      OP_AND: begin dec.alu_sel = ALU_AND; dec.is_reg_wr = 1'b1; end
      OP_OR:  begin dec.alu_sel = ALU_OR;  dec.is_reg_wr = 1'b1; end
      OP_LD: begin
        dec.mem_op     = 1'b1;
        dec.mem_to_reg = 1'b1;
        dec.is_reg_wr  = 1'b1;
      end
      OP_ST: begin
        dec.mem_op    = 1'b1;
        dec.is_mem_wr = 1'b1;
      end
      OP_HALT: dec.is_halt = 1'b1;
      default: dec.is_illegal = op_is_illegal(op);
    endcase
  end

endmodule

// File: rtl/tisc_control_unit.sv
// Multi-cycle FETCH/DECODE/EXEC control FSM with start/halt, retire counter, sticky illegal flag.
// Latency: ALU/illegal-NOP 3 cycles from FETCH to pc_en; LD/ST 3 + cycles spent with mem_ready low.
// Backpressure: LD/ST hold in EXEC until mem_ready; start is ignored while busy.
module tisc_control_unit
  import tisc_pkg::*;
#(
  parameter int RETIRE_W     = 16,
  parameter bit ILLEGAL_HALT = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  tisc_control_unit_if.master bus
);

  state_e              state_q, state_d;
  logic [3:0]          op_q, op_d;
  logic                illegal_q, illegal_d;
  logic [RETIRE_W-1:0] retired_q, retired_d;

  decode_t dec;
  logic    exec_done;
  logic    dec_vis;

  tisc_opcode_decoder u_dec (
    .op  (op_q),
    .dec (dec)
  );

  // State, latched opcode, sticky flag and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      op_q      <= 4'h0;
      illegal_q <= 1'b0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      illegal_q <= illegal_d;
      retired_q <= retired_d;
    end
  end

  // Next-state logic; an instruction completes on the EXEC cycle where exec_done is high.
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    illegal_d = illegal_q;
    retired_d = retired_q;
    exec_done = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) state_d = FETCH;
      end
      FETCH: begin
        op_d    = bus.opcode;
        state_d = DECODE;
      end
      DECODE: begin
        if (dec.is_illegal) illegal_d = 1'b1;
        // A HALT decode takes priority over any start seen in the same cycle.
        if (dec.is_halt || (dec.is_illegal && ILLEGAL_HALT)) state_d = HALT;
        else                                                 state_d = EXEC;
      end
      EXEC: begin
        // Memory ops wait for the data memory; everything else finishes at once.
        exec_done = !dec.mem_op || bus.mem_ready;
        if (exec_done) state_d = FETCH;
      end
      HALT: begin
        if (bus.start) state_d = FETCH;
      end
      default: state_d = IDLE;
    endcase
    if (exec_done) retired_d = retired_q + RETIRE_W'(1);
  end

  // Outputs are decoded from registered state, so an async reset clears them at once.
  always_comb begin
    dec_vis          = (state_q == DECODE) || (state_q == EXEC);
    bus.alu_sel      = dec_vis ? dec.alu_sel    : 2'd0;
    bus.mem_op       = dec_vis ? dec.mem_op     : 1'b0;
    bus.mem_to_reg   = dec_vis ? dec.mem_to_reg : 1'b0;
    bus.pc_en        = exec_done;
    bus.reg_write_en = exec_done && dec.is_reg_wr;
    bus.mem_write_en = exec_done && dec.is_mem_wr;
    bus.busy         = (state_q != IDLE) && (state_q != HALT);
    bus.halted       = (state_q == HALT);
    bus.illegal      = illegal_q;
    bus.retired      = retired_q;
  end

endmodule
